replay_packet_unpacker: RTL and testbench

Upstream stage of the per-channel two-way-handshake replayers. It receives packed replay packets from the replay-log reader, one beat per cycle, and reassembles each packet into per-channel replay-bus entries. Each entry carries `in_valid`, `logb_valid`, `logb_data` and `loge_valid`, and every channel has its own handshake. A packet is retired only after every addressed channel's replayer has accepted its entry.

---
 rtl/replay_packet_unpacker_if.sv | 17 +
 rtl/replay_packet_unpacker.sv | 67 ++++++
 tb/tb_replay_packet_unpacker.sv | 110 +++++++++++
 3 files changed

// File: rtl/replay_packet_unpacker_if.sv
// replay_packet_unpacker_if: packet-beat input bus plus per-channel replay-entry bus.
// master: the unpacker side (drives pk_ready and every ch_* entry field).
// slave: the log reader and replayers (drive pk_valid, pk_data and ch_in_ready).
interface replay_packet_unpacker_if #(parameter int NUM_CH = 2, parameter int DATA_WIDTH = 12);
  logic                         pk_valid;
  logic                         pk_ready;
  logic [DATA_WIDTH-1:0]        pk_data;
  logic [NUM_CH-1:0]            ch_in_valid;
  logic [NUM_CH-1:0]            ch_in_ready;
  logic [NUM_CH-1:0]            ch_logb_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_logb_data;
  logic [NUM_CH-1:0]            ch_loge_valid;
  modport master (input pk_valid, pk_data, ch_in_ready,
                  output pk_ready, ch_in_valid, ch_logb_valid, ch_logb_data, ch_loge_valid);
  modport slave (output pk_valid, pk_data, ch_in_ready,
                 input pk_ready, ch_in_valid, ch_logb_valid, ch_logb_data, ch_loge_valid);
endinterface

// File: rtl/replay_packet_unpacker.sv
// replay_packet_unpacker: reassembles packed replay packets into per-channel replay entries.
// Ports: clk, rstn (sync, active-low), bus (master modport of replay_packet_unpacker_if).
module replay_packet_unpacker #(
  parameter int NUM_CH = 2,
  parameter int DATA_WIDTH = 12
) (
  input logic clk,
  input logic rstn,
  replay_packet_unpacker_if.master bus
);
  if (DATA_WIDTH < 2 * NUM_CH) begin : g_bad_width
    $error("DATA_WIDTH must be at least 2*NUM_CH");
  end
  typedef enum logic [1:0] {HDR, PLD, DISP} state_t;
  state_t state, state_nx;
  logic [NUM_CH-1:0] logb_mask, loge_mask, remain, pending, lowest, accepted, hdr_logb, hdr_loge;
  logic [NUM_CH*DATA_WIDTH-1:0] data;
  logic fire, disp;
  assign hdr_logb = bus.pk_data[NUM_CH-1:0];
  assign hdr_loge = bus.pk_data[2*NUM_CH-1:NUM_CH];
  assign fire = bus.pk_valid && bus.pk_ready;
  assign disp = state == DISP;
  // one-hot of the lowest set bit of remain: the channel the next payload beat belongs to
  assign lowest = remain & (~remain + NUM_CH'(1));
  assign accepted = bus.ch_in_valid & bus.ch_in_ready;
  always_comb begin
    state_nx = state;
    if (state == HDR && fire)
      state_nx = hdr_logb != '0 ? PLD : hdr_loge != '0 ? DISP : HDR;
    if (state == PLD && fire && remain == lowest)
      state_nx = DISP;
    if (disp && (pending & ~accepted) == '0)
      state_nx = HDR;
  end
  always_ff @(posedge clk)
    state <= !rstn ? HDR : state_nx;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      logb_mask <= '0;
      loge_mask <= '0;
      remain    <= '0;
      pending   <= '0;
      data      <= '0;
    end else begin
      if (state == HDR && fire) begin
        logb_mask <= hdr_logb;
        loge_mask <= hdr_loge;
        remain    <= hdr_logb;
        pending   <= {NUM_CH{|hdr_loge}};
        data      <= '0;
      end
      if (state == PLD && fire) begin
        remain  <= remain & ~lowest;
        pending <= logb_mask | {NUM_CH{|loge_mask}};
        for (int i = 0; i < NUM_CH; i++)
          if (lowest[i]) data[i*DATA_WIDTH +: DATA_WIDTH] <= bus.pk_data;
      end
      if (disp)
        pending <= pending & ~accepted;
    end
  end
  assign bus.pk_ready      = rstn && !disp;
  assign bus.ch_in_valid   = disp ? pending : '0;
  assign bus.ch_logb_valid = disp ? logb_mask : '0;
  assign bus.ch_loge_valid = disp ? loge_mask : '0;
  assign bus.ch_logb_data  = data;
endmodule

// File: tb/tb_replay_packet_unpacker.sv
// tb_replay_packet_unpacker: directed vector bench for replay_packet_unpacker (NUM_CH=2, DATA_WIDTH=12).
module tb_replay_packet_unpacker;
  logic clk = 1'b0;
  logic rstn;
  int n_vec = 0;
  int n_bad = 0;
  typedef struct {
    logic        valid;
    logic [11:0] data;
    logic [1:0]  ready;
    logic        e_pr;
    logic [1:0]  e_inv;
    logic [1:0]  e_lbv;
    logic [1:0]  e_lev;
    logic [23:0] e_data;
  } vec_t;
  vec_t tv[$];
  replay_packet_unpacker_if #(.NUM_CH(2), .DATA_WIDTH(12)) bus ();
  replay_packet_unpacker #(.NUM_CH(2), .DATA_WIDTH(12)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic v, logic [11:0] d, logic [1:0] r, logic pr,
                              logic [1:0] inv, logic [1:0] lbv, logic [1:0] lev, logic [23:0] ed);
    vec_t t;
    t.valid = v; t.data = d; t.ready = r; t.e_pr = pr;
    t.e_inv = inv; t.e_lbv = lbv; t.e_lev = lev; t.e_data = ed;
    return t;
  endfunction
  task automatic check(string name, logic pr, logic [1:0] inv, logic [1:0] lbv, logic [1:0] lev, logic [23:0] ed);
    n_vec++;
    if ({bus.pk_ready, bus.ch_in_valid, bus.ch_logb_valid, bus.ch_loge_valid, bus.ch_logb_data} !== {pr, inv, lbv, lev, ed}) begin
      n_bad++;
      $display("FAIL %s: got pr=%b inv=%b lbv=%b lev=%b data=%h, want pr=%b inv=%b lbv=%b lev=%b data=%h",
               name, bus.pk_ready, bus.ch_in_valid, bus.ch_logb_valid, bus.ch_loge_valid, bus.ch_logb_data,
               pr, inv, lbv, lev, ed);
    end
  endtask
  task automatic drive(logic v, logic [11:0] d, logic [1:0] r);
    bus.pk_valid = v;
    bus.pk_data = d;
    bus.ch_in_ready = r;
  endtask
  initial begin
    // full packet 0x00B: logb=11 loge=10, payload 0x005 then 0x006, both channels ready
    tv.push_back(mk(1, 12'h00B, 2'b11, 1, 2'b00, 2'b00, 2'b00, 24'h000000));
    tv.push_back(mk(1, 12'h005, 2'b11, 1, 2'b00, 2'b00, 2'b00, 24'h000000));
    tv.push_back(mk(1, 12'h006, 2'b11, 1, 2'b00, 2'b00, 2'b00, 24'h000005));
    tv.push_back(mk(0, 12'h000, 2'b11, 0, 2'b11, 2'b11, 2'b10, 24'h006005));
    tv.push_back(mk(0, 12'h000, 2'b00, 1, 2'b00, 2'b00, 2'b00, 24'h006005));
    // loge-only packet 0x004
    tv.push_back(mk(1, 12'h004, 2'b00, 1, 2'b00, 2'b00, 2'b00, 24'h006005));
    tv.push_back(mk(0, 12'h000, 2'b00, 0, 2'b11, 2'b00, 2'b01, 24'h000000));
    tv.push_back(mk(0, 12'h000, 2'b11, 0, 2'b11, 2'b00, 2'b01, 24'h000000));
    tv.push_back(mk(0, 12'h000, 2'b00, 1, 2'b00, 2'b00, 2'b00, 24'h000000));
    // skewed acceptance, with a beat held at the input during DISP
    tv.push_back(mk(1, 12'h002, 2'b01, 1, 2'b00, 2'b00, 2'b00, 24'h000000));
    tv.push_back(mk(1, 12'h0AB, 2'b01, 1, 2'b00, 2'b00, 2'b00, 24'h000000));
    tv.push_back(mk(0, 12'h000, 2'b01, 0, 2'b10, 2'b10, 2'b00, 24'h0AB000));
    tv.push_back(mk(0, 12'h000, 2'b01, 0, 2'b10, 2'b10, 2'b00, 24'h0AB000));
    tv.push_back(mk(1, 12'h004, 2'b01, 0, 2'b10, 2'b10, 2'b00, 24'h0AB000));
    tv.push_back(mk(1, 12'h004, 2'b01, 0, 2'b10, 2'b10, 2'b00, 24'h0AB000));
    tv.push_back(mk(1, 12'h004, 2'b01, 0, 2'b10, 2'b10, 2'b00, 24'h0AB000));
    tv.push_back(mk(1, 12'h004, 2'b10, 0, 2'b10, 2'b10, 2'b00, 24'h0AB000));
    tv.push_back(mk(1, 12'h004, 2'b00, 1, 2'b00, 2'b00, 2'b00, 24'h0AB000));
    tv.push_back(mk(0, 12'h000, 2'b00, 0, 2'b11, 2'b00, 2'b01, 24'h000000));
    tv.push_back(mk(0, 12'h000, 2'b11, 0, 2'b11, 2'b00, 2'b01, 24'h000000));
    tv.push_back(mk(0, 12'h000, 2'b00, 1, 2'b00, 2'b00, 2'b00, 24'h000000));
    // empty header is dropped
    tv.push_back(mk(1, 12'h000, 2'b11, 1, 2'b00, 2'b00, 2'b00, 24'h000000));
    tv.push_back(mk(0, 12'h000, 2'b11, 1, 2'b00, 2'b00, 2'b00, 24'h000000));
    tv.push_back(mk(0, 12'h000, 2'b11, 1, 2'b00, 2'b00, 2'b00, 24'h000000));
    rstn = 1'b0;
    drive(0, 12'h000, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 0, 2'b00, 2'b00, 2'b00, 24'h0);
    rstn = 1'b1;
    @(negedge clk);
    check("reset_release", 1, 2'b00, 2'b00, 2'b00, 24'h0);
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].valid, tv[i].data, tv[i].ready);
      #1;
      check($sformatf("vec%0d", i), tv[i].e_pr, tv[i].e_inv, tv[i].e_lbv, tv[i].e_lev, tv[i].e_data);
      @(negedge clk);
    end
    // mid-packet reset after header 0x003, before any payload beat
    drive(1, 12'h003, 2'b00);
    @(negedge clk);
    drive(0, 12'h000, 2'b00);
    rstn = 1'b0;
    #1;
    check("midrst_low", 0, 2'b00, 2'b00, 2'b00, 24'h0);
    @(negedge clk);
    check("midrst_after_edge", 0, 2'b00, 2'b00, 2'b00, 24'h0);
    rstn = 1'b1;
    @(negedge clk);
    drive(1, 12'h004, 2'b00);
    #1;
    check("midrst_hdr_ready", 1, 2'b00, 2'b00, 2'b00, 24'h0);
    @(negedge clk);
    drive(0, 12'h000, 2'b11);
    #1;
    check("midrst_loge_disp", 0, 2'b11, 2'b00, 2'b01, 24'h0);
    @(negedge clk);
    drive(0, 12'h000, 2'b00);
    #1;
    check("midrst_retired", 1, 2'b00, 2'b00, 2'b00, 24'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
